// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO read-side drain block and its skid buffer.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_OCC_W = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/fifo_rd_drain_if.sv
// Handshake bundle between the drain block, the DUT read port and the downstream stream.
interface fifo_rd_drain_if #(
  parameter int DAT_W = 32,
  parameter int LEN_W = 7
);

  logic             Start;
  logic [LEN_W-1:0] Burst_len;
  logic             Empty;
  logic             Rden;
  logic [DAT_W-1:0] Dataout;
  logic [DAT_W-1:0] Out_data;
  logic             Out_valid;
  logic             Out_ready;
  logic             Busy;
  logic             Done;
  logic [LEN_W-1:0] Count;

  modport master (
    output Start, Burst_len, Empty, Dataout, Out_ready,
    input  Rden, Out_data, Out_valid, Busy, Done, Count
  );

  modport slave (
    input  Start, Burst_len, Empty, Dataout, Out_ready,
    output Rden, Out_data, Out_valid, Busy, Done, Count
  );

endinterface

// File: rtl/rd_skid_buf.sv
// Two-entry in-order buffer that absorbs the DUT's one-cycle read latency.
module rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DAT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DAT_W-1:0]      din,
  input  logic                  ready,
  output logic [SKID_OCC_W-1:0] occ,
  output logic [DAT_W-1:0]      dout,
  output logic                  valid
);

  logic [DAT_W-1:0]      head_q, head_d;
  logic [DAT_W-1:0]      tail_q, tail_d;
  logic [SKID_OCC_W-1:0] occ_q, occ_d;
  logic                  pop;

  assign valid = (occ_q != '0);
  assign dout  = head_q;
  assign occ   = occ_q;
  assign pop   = valid && ready;

  // Head always holds the oldest word; a pop shifts the tail entry forward.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    unique case ({wr_en, pop})
      2'b10: begin
        if (occ_q == '0) head_d = din;
        else             tail_d = din;
        occ_d = occ_q + SKID_OCC_W'(1);
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - SKID_OCC_W'(1);
      end
      2'b11: begin
        if (occ_q == SKID_OCC_W'(SKID_DEPTH)) begin
          head_d = tail_q;
          tail_d = din;
        end else begin
          head_d = din;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

endmodule

// File: rtl/fifo_rd_drain.sv
// Burst reader for the FIFO/LIFO read port: issues Rden against Empty with
// skid-buffer credit and streams the words out as valid/ready.
module fifo_rd_drain
  import fifo_rd_pkg::*;
#(
  parameter int DAT_W = 32,
  parameter int LEN_W = 7
) (
  input logic           Clk,
  input logic           Rst,
  fifo_rd_drain_if.slave bus
);

  rd_state_e             state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      issued_q, issued_d;
  logic [LEN_W-1:0]      count_q, count_d;
  logic                  inflight_q;
  logic                  rden;
  logic                  handshake;
  logic                  creditOk;
  logic [SKID_OCC_W-1:0] occ;
  logic [SKID_OCC_W:0]   slotsUsed;
  logic [SKID_OCC_W:0]   slotsAvail;

  rd_skid_buf #(.DAT_W(DAT_W)) u_skid (
    .clk   (Clk),
    .rst_n (Rst),
    .wr_en (inflight_q),
    .din   (bus.Dataout),
    .ready (bus.Out_ready),
    .occ   (occ),
    .dout  (bus.Out_data),
    .valid (bus.Out_valid)
  );

  assign handshake = bus.Out_valid && bus.Out_ready;

  // A slot freed by this cycle's handshake is usable, so back-to-back reads sustain one word per cycle.
  assign slotsUsed  = {1'b0, occ} + {{SKID_OCC_W{1'b0}}, inflight_q};
  assign slotsAvail = (SKID_OCC_W + 1)'(SKID_DEPTH) + {{SKID_OCC_W{1'b0}}, handshake};
  assign creditOk   = (slotsUsed < slotsAvail);

  assign bus.Rden  = rden;
  assign bus.Busy  = (state_q != IDLE);
  assign bus.Done  = (state_q == DONE);
  assign bus.Count = count_q;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    issued_d = issued_q;
    count_d  = count_q;
    rden     = 1'b0;

    if (handshake) count_d = count_q + LEN_W'(1);

    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          len_d    = bus.Burst_len;
          issued_d = '0;
          count_d  = '0;
          state_d  = (bus.Burst_len == '0) ? DONE : READ;
        end
      end
      READ: begin
        rden = !bus.Empty && (issued_q < len_q) && creditOk;
        if (rden) begin
          issued_d = issued_q + LEN_W'(1);
          if (issued_d == len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((occ == '0) && !inflight_q && (count_q == len_q)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Clearing inflight on reset drops any word the DUT returns for a pre-reset Rden.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      count_q    <= count_d;
      inflight_q <= rden;
    end
  end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Self-checking bench: behavioural FIFO/LIFO read port plus an output scoreboard.
module tb_fifo_rd_drain;

  logic Clk;
  logic Rst;

  fifo_rd_drain_if #(.DAT_W(32), .LEN_W(7)) bus ();

  fifo_rd_drain #(.DAT_W(32), .LEN_W(7)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  int checks = 0;
  int errors = 0;

  logic [31:0] memQ[$];
  logic [31:0] expQ[$];
  logic [31:0] lateQ[$];
  bit          lifoMode;
  bit          toggleReady;
  int          n, rdenCnt, firstRden, lastRden, firstValid;
  int          doneCnt, doneAt, hsCnt, firstHs, lastHs;
  int          lateAt, extraAt;
  logic        prevStall;
  logic [31:0] prevData;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic writeWord(input logic [31:0] w);
    memQ.push_back(w);
    if (!lifoMode) expQ.push_back(w);
    bus.Empty = 1'b0;
  endtask

  task automatic clearModel();
    memQ.delete();
    expQ.delete();
    lateQ.delete();
    lifoMode      = 1'b0;
    toggleReady   = 1'b0;
    lateAt        = -1;
    extraAt       = -1;
    bus.Out_ready = 1'b1;
    bus.Empty     = 1'b1;
  endtask

  // Sample at the falling edge, then model the DUT read port just after the rising edge.
  task automatic cycle();
    logic        rdenNow;
    logic [31:0] w;
    @(negedge Clk);
    n++;
    rdenNow = bus.Rden;
    if (bus.Rden === 1'b1) begin
      rdenCnt++;
      if (firstRden == 0) firstRden = n;
      lastRden = n;
      checkOutput("rdenWhileEmpty", bus.Empty, 0);
    end
    if (bus.Out_valid === 1'b1 && firstValid == 0) firstValid = n;
    if (prevStall) begin
      checkOutput("stallValid", bus.Out_valid, 1);
      checkOutput("stallData", bus.Out_data, prevData);
    end
    if (bus.Out_valid === 1'b1 && bus.Out_ready === 1'b1) begin
      hsCnt++;
      if (firstHs == 0) firstHs = n;
      lastHs = n;
      if (expQ.size() > 0) begin
        w = expQ.pop_front();
        checkOutput("data", bus.Out_data, w);
      end else begin
        checkOutput("sbUnderflow", expQ.size(), 1);
      end
    end
    prevStall = (bus.Out_valid === 1'b1) && (bus.Out_ready === 1'b0);
    prevData  = bus.Out_data;
    if (bus.Done === 1'b1) begin
      doneCnt++;
      doneAt = n;
    end
    @(posedge Clk);
    #1;
    if (rdenNow === 1'b1 && memQ.size() > 0) begin
      if (lifoMode) bus.Dataout = memQ.pop_back();
      else          bus.Dataout = memQ.pop_front();
    end
    if (n == lateAt) begin
      while (lateQ.size() > 0) writeWord(lateQ.pop_front());
    end
    if (n == extraAt) begin
      bus.Start     = 1'b1;
      bus.Burst_len = 7'd2;
    end else if (n == extraAt + 1) begin
      bus.Start     = 1'b0;
      bus.Burst_len = 7'd0;
    end
    if (toggleReady) bus.Out_ready = ~bus.Out_ready;
    bus.Empty = (memQ.size() == 0);
  endtask

  task automatic applyStimulus(input int len);
    n = 0; rdenCnt = 0; firstRden = 0; lastRden = 0; firstValid = 0;
    doneCnt = 0; doneAt = 0; hsCnt = 0; firstHs = 0; lastHs = 0;
    bus.Start     = 1'b1;
    bus.Burst_len = 7'(len);
    cycle();
    bus.Start     = 1'b0;
    bus.Burst_len = 7'd0;
  endtask

  task automatic runToDone(input int budget);
    int k;
    k = 0;
    while (doneCnt == 0 && k < budget) begin
      cycle();
      k++;
    end
    if (doneCnt == 0) checkOutput("doneTimeout", doneCnt, 1);
    repeat (3) cycle();
    checkOutput("donePulses", doneCnt, 1);
  endtask

  initial begin
    int k;
    Rst           = 1'b0;
    bus.Start     = 1'b0;
    bus.Burst_len = 7'd0;
    bus.Dataout   = 32'd0;
    prevStall     = 1'b0;
    prevData      = 32'd0;
    n             = 0;
    clearModel();

    repeat (2) cycle();
    checkOutput("rstRden", bus.Rden, 0);
    checkOutput("rstValid", bus.Out_valid, 0);
    checkOutput("rstBusy", bus.Busy, 0);
    checkOutput("rstDone", bus.Done, 0);
    checkOutput("rstCount", bus.Count, 0);
    checkOutput("rstData", bus.Out_data, 0);
    Rst = 1'b1;
    cycle();

    $display("[TB] basic burst");
    for (int i = 0; i < 4; i++) writeWord(32'h11 + i);
    applyStimulus(4);
    runToDone(50);
    checkOutput("basicFirstRden", firstRden, 2);
    checkOutput("basicFirstValid", firstValid, 4);
    checkOutput("basicRdenCnt", rdenCnt, 4);
    checkOutput("basicRdenRun", lastRden - firstRden, 3);
    checkOutput("basicHsCnt", hsCnt, 4);
    checkOutput("basicHsRun", lastHs - firstHs, 3);
    checkOutput("basicCount", bus.Count, 4);
    checkOutput("basicLeft", expQ.size(), 0);

    $display("[TB] backpressure");
    clearModel();
    for (int i = 0; i < 8; i++) writeWord(32'h41 + i);
    toggleReady = 1'b1;
    applyStimulus(8);
    runToDone(100);
    checkOutput("bpHsCnt", hsCnt, 8);
    checkOutput("bpRdenCnt", rdenCnt, 8);
    checkOutput("bpCount", bus.Count, 8);
    checkOutput("bpLeft", expQ.size(), 0);

    $display("[TB] empty stall");
    clearModel();
    writeWord(32'h21);
    writeWord(32'h22);
    for (int i = 0; i < 3; i++) lateQ.push_back(32'h23 + i);
    lateAt = 10;
    applyStimulus(5);
    runToDone(100);
    checkOutput("stallHsCnt", hsCnt, 5);
    checkOutput("stallRdenCnt", rdenCnt, 5);
    checkOutput("stallResume", lastRden > lateAt, 1);
    checkOutput("stallDoneAfterLast", doneAt > lastHs, 1);
    checkOutput("stallCount", bus.Count, 5);

    $display("[TB] zero length");
    clearModel();
    writeWord(32'h99);
    applyStimulus(0);
    runToDone(10);
    checkOutput("zeroDoneAt", doneAt, 2);
    checkOutput("zeroRdenCnt", rdenCnt, 0);
    checkOutput("zeroHsCnt", hsCnt, 0);
    checkOutput("zeroCount", bus.Count, 0);

    $display("[TB] ignored start");
    clearModel();
    for (int i = 0; i < 6; i++) writeWord(32'h51 + i);
    extraAt = 3;
    applyStimulus(6);
    runToDone(100);
    checkOutput("ignHsCnt", hsCnt, 6);
    checkOutput("ignRdenCnt", rdenCnt, 6);
    checkOutput("ignCount", bus.Count, 6);

    $display("[TB] reset mid-burst");
    clearModel();
    for (int i = 0; i < 10; i++) writeWord(32'h31 + i);
    applyStimulus(10);
    k = 0;
    while (hsCnt < 3 && k < 50) begin
      cycle();
      k++;
    end
    if (hsCnt < 3) checkOutput("midTimeout", hsCnt, 3);
    Rst = 1'b0;
    cycle();
    Rst = 1'b1;
    checkOutput("midRden", bus.Rden, 0);
    checkOutput("midValid", bus.Out_valid, 0);
    checkOutput("midBusy", bus.Busy, 0);
    checkOutput("midCount", bus.Count, 0);
    prevStall = 1'b0;
    expQ = memQ;
    applyStimulus(2);
    runToDone(50);
    checkOutput("postRstHsCnt", hsCnt, 2);
    checkOutput("postRstCount", bus.Count, 2);

    $display("[TB] lifo mode");
    clearModel();
    lifoMode = 1'b1;
    writeWord(32'hA);
    writeWord(32'hB);
    writeWord(32'hC);
    expQ.push_back(32'hC);
    expQ.push_back(32'hB);
    expQ.push_back(32'hA);
    applyStimulus(3);
    runToDone(50);
    repeat (5) cycle();
    checkOutput("lifoHsCnt", hsCnt, 3);
    checkOutput("lifoEmpty", bus.Empty, 1);
    checkOutput("lifoRdenCnt", rdenCnt, 3);
    checkOutput("lifoCount", bus.Count, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
